aes_decipher_block: RTL and testbench

- Sequencing controller for one AES block decryption.
- Latches a 128-bit ciphertext and drives state and round type to the combinational aes_decipher_round datapath each cycle. Requests round keys from the key memory by index and registers the datapath result back into its state register.
- Outputs the plaintext with a ready/valid indication.
- Sits between the core control/register interface (upstream) and the decipher round datapath plus key memory (downstream).

---
 rtl/aes_decipher_block.sv | 128 ++++++++++++
 tb/tb_aes_decipher_block.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decipher_block.sv
// Sequencing controller for one AES block decryption: walks the round keys from
// NUM_ROUNDS down to 0 and feeds the combinational decipher round datapath.
module aes_decipher_block #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         keymem_ready,
    input  logic [127:0] block,
    output logic         ready,
    output logic         result_valid,
    output logic [127:0] result,
    output logic [3:0]   round_key_idx,
    input  logic [127:0] round_key,
    output logic [1:0]   round_type,
    output logic [127:0] round_state,
    input  logic [127:0] round_state_new
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StInit  = 2'd1;
    localparam logic [1:0] StMain  = 2'd2;
    localparam logic [1:0] StFinal = 2'd3;

    localparam logic [1:0] RoundInit  = 2'd0;
    localparam logic [1:0] RoundMain  = 2'd1;
    localparam logic [1:0] RoundFinal = 2'd2;
    localparam logic [1:0] RoundNop   = 2'd3;

    logic [1:0]   fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   ctr_q, ctr_d;
    logic         ready_q, ready_d;
    logic         valid_q, valid_d;
    logic [127:0] result_q, result_d;

    // The key itself is consumed by the datapath, not by this controller.
    logic unused_round_key;
    assign unused_round_key = ^round_key;

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        ctr_d    = ctr_q;
        ready_d  = ready_q;
        valid_d  = valid_q;
        result_d = result_q;
        case (fsm_q)
            StIdle: begin
                if (next && keymem_ready) begin
                    state_d = block;
                    valid_d = 1'b0;
                    ready_d = 1'b0;
                    ctr_d   = 4'(NUM_ROUNDS - 1);
                    fsm_d   = StInit;
                end
            end
            StInit: begin
                state_d = round_state_new;
                fsm_d   = StMain;
            end
            StMain: begin
                state_d = round_state_new;
                ctr_d   = ctr_q - 4'd1;
                if (ctr_q == 4'd1) begin
                    fsm_d = StFinal;
                end
            end
            StFinal: begin
                state_d  = round_state_new;
                result_d = round_state_new;
                valid_d  = 1'b1;
                ready_d  = 1'b1;
                fsm_d    = StIdle;
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q    <= StIdle;
            state_q  <= '0;
            ctr_q    <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            ctr_q    <= ctr_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    // Round controls decode from registered state only, so next/block never reach outputs.
    always_comb begin
        round_type    = RoundNop;
        round_key_idx = 4'd0;
        case (fsm_q)
            StInit: begin
                round_type    = RoundInit;
                round_key_idx = 4'(NUM_ROUNDS);
            end
            StMain: begin
                round_type    = RoundMain;
                round_key_idx = ctr_q;
            end
            StFinal: begin
                round_type    = RoundFinal;
                round_key_idx = 4'd0;
            end
            default: begin
                round_type    = RoundNop;
                round_key_idx = 4'd0;
            end
        endcase
    end

    assign round_state  = state_q;
    assign ready        = ready_q;
    assign result_valid = valid_q;
    assign result       = result_q;

endmodule

// File: tb/tb_aes_decipher_block.sv
// Directed bench for aes_decipher_block using an XOR stub datapath with key[i] = {16{i}}.
module tb_aes_decipher_block;

    logic         clk;
    logic         reset;
    logic         next;
    logic         keymem_ready;
    logic [127:0] block;
    logic         ready;
    logic         result_valid;
    logic [127:0] result;
    logic [3:0]   round_key_idx;
    logic [127:0] round_key;
    logic [1:0]   round_type;
    logic [127:0] round_state;
    logic [127:0] round_state_new;

    logic         next2;
    logic [127:0] block2;
    logic         ready2;
    logic         result_valid2;
    logic [127:0] result2;
    logic [3:0]   round_key_idx2;
    logic [127:0] round_key2;
    logic [1:0]   round_type2;
    logic [127:0] round_state2;
    logic [127:0] round_state_new2;

    int n_cmp;
    int n_err;

    aes_decipher_block #(.NUM_ROUNDS(10)) u_dut (
        .clk             (clk),
        .reset           (reset),
        .next            (next),
        .keymem_ready    (keymem_ready),
        .block           (block),
        .ready           (ready),
        .result_valid    (result_valid),
        .result          (result),
        .round_key_idx   (round_key_idx),
        .round_key       (round_key),
        .round_type      (round_type),
        .round_state     (round_state),
        .round_state_new (round_state_new)
    );

    aes_decipher_block #(.NUM_ROUNDS(14)) u_dut14 (
        .clk             (clk),
        .reset           (reset),
        .next            (next2),
        .keymem_ready    (keymem_ready),
        .block           (block2),
        .ready           (ready2),
        .result_valid    (result_valid2),
        .result          (result2),
        .round_key_idx   (round_key_idx2),
        .round_key       (round_key2),
        .round_type      (round_type2),
        .round_state     (round_state2),
        .round_state_new (round_state_new2)
    );

    assign round_key        = {16{4'h0, round_key_idx}};
    assign round_state_new  = round_state ^ round_key;
    assign round_key2       = {16{4'h0, round_key_idx2}};
    assign round_state_new2 = round_state2 ^ round_key2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", ready); end
        n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", result_valid); end
        n_cmp++; if (result !== 128'h0) begin n_err++; $display("FAIL reset_result got %h exp 0", result); end
        n_cmp++; if (round_type !== 2'd3) begin n_err++; $display("FAIL reset_type got %0d exp 3", round_type); end
        n_cmp++; if (round_key_idx !== 4'd0) begin n_err++; $display("FAIL reset_idx got %0d exp 0", round_key_idx); end
        n_cmp++; if (round_state !== 128'h0) begin n_err++; $display("FAIL reset_state got %h exp 0", round_state); end
        n_cmp++; if (ready2 !== 1'b1) begin n_err++; $display("FAIL reset_ready14 got %b exp 1", ready2); end
    endtask

    // Full 10-round operation with trace checks; optional disturbance (next + keymem_ready=0) at cycle dk.
    task automatic run_trace(input logic [127:0] blk, input int dk, input string name);
        logic [127:0] exp_st;
        logic [3:0]   exp_idx;
        logic [1:0]   exp_type;
        block = blk;
        next  = 1'b1;
        step();
        next  = 1'b0;
        block = ~blk;
        exp_st = blk;
        for (int k = 0; k <= 10; k++) begin
            exp_idx  = 4'(10 - k);
            exp_type = (k == 0) ? 2'd0 : ((k == 10) ? 2'd2 : 2'd1);
            n_cmp++; if (round_key_idx !== exp_idx) begin n_err++;
                $display("FAIL %s idx c%0d got %0d exp %0d", name, k, round_key_idx, exp_idx); end
            n_cmp++; if (round_type !== exp_type) begin n_err++;
                $display("FAIL %s type c%0d got %0d exp %0d", name, k, round_type, exp_type); end
            n_cmp++; if (round_state !== exp_st) begin n_err++;
                $display("FAIL %s state c%0d got %h exp %h", name, k, round_state, exp_st); end
            n_cmp++; if (ready !== 1'b0 || result_valid !== 1'b0) begin n_err++;
                $display("FAIL %s busy c%0d got rdy=%b vld=%b exp 0 0", name, k, ready, result_valid); end
            exp_st = exp_st ^ {16{4'h0, exp_idx}};
            if (k == dk) begin
                next = 1'b1;
                keymem_ready = 1'b0;
            end
            step();
            next = 1'b0;
            keymem_ready = 1'b1;
        end
        n_cmp++; if (ready !== 1'b1 || result_valid !== 1'b1) begin n_err++;
            $display("FAIL %s done got rdy=%b vld=%b exp 1 1", name, ready, result_valid); end
        n_cmp++; if (result !== (blk ^ {16{8'h0b}})) begin n_err++;
            $display("FAIL %s result got %h exp %h", name, result, blk ^ {16{8'h0b}}); end
        n_cmp++; if (round_type !== 2'd3 || round_key_idx !== 4'd0) begin n_err++;
            $display("FAIL %s idle got type=%0d idx=%0d exp 3 0", name, round_type, round_key_idx); end
    endtask

    task automatic test_trace();
        run_trace(128'h69c4e0d86a7b0430d8cdb78070b4c55a, -1, "trace");
    endtask

    task automatic test_ignore();
        logic [127:0] held;
        held = 128'h69c4e0d86a7b0430d8cdb78070b4c55a ^ {16{8'h0b}};
        keymem_ready = 1'b0;
        block = 128'hdeadbeef_00000000_11111111_22222222;
        next = 1'b1;
        step();
        next = 1'b0;
        keymem_ready = 1'b1;
        step();
        n_cmp++; if (ready !== 1'b1 || round_type !== 2'd3) begin n_err++;
            $display("FAIL ignore_idle got rdy=%b type=%0d exp 1 3", ready, round_type); end
        n_cmp++; if (result_valid !== 1'b1 || result !== held) begin n_err++;
            $display("FAIL ignore_hold got vld=%b res=%h exp 1 %h", result_valid, result, held); end
        n_cmp++; if (round_state !== held) begin n_err++;
            $display("FAIL ignore_state got %h exp %h", round_state, held); end
        // Next while busy, with keymem_ready dropped in the same cycle.
        run_trace(128'h0123456789abcdef_fedcba9876543210, 4, "busy");
    endtask

    task automatic test_reset_mid();
        block = 128'hcafef00d_cafef00d_cafef00d_cafef00d;
        next = 1'b1;
        step();
        next = 1'b0;
        for (int k = 0; k < 5; k++) step();
        n_cmp++; if (round_key_idx !== 4'd5 || round_type !== 2'd1) begin n_err++;
            $display("FAIL rmid_pre got idx=%0d type=%0d exp 5 1", round_key_idx, round_type); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (ready !== 1'b1 || result_valid !== 1'b0) begin n_err++;
            $display("FAIL rmid_flags got rdy=%b vld=%b exp 1 0", ready, result_valid); end
        n_cmp++; if (result !== 128'h0 || round_state !== 128'h0) begin n_err++;
            $display("FAIL rmid_data got res=%h st=%h exp 0 0", result, round_state); end
        n_cmp++; if (round_type !== 2'd3 || round_key_idx !== 4'd0) begin n_err++;
            $display("FAIL rmid_idle got type=%0d idx=%0d exp 3 0", round_type, round_key_idx); end
        run_trace(128'h00112233445566778899aabbccddeeff, -1, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_trace(128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd, -1, "b2b_first");
        run_trace(128'h13579bdf_2468ace0_0f1e2d3c_4b5a6978, -1, "b2b_second");
    endtask

    task automatic test_rounds14();
        int lowc;
        logic [127:0] blk;
        blk = 128'h8ea2b7ca516745bfeafc49904b496089;
        block2 = blk;
        next2 = 1'b1;
        step();
        next2 = 1'b0;
        n_cmp++; if (round_key_idx2 !== 4'd14 || round_type2 !== 2'd0) begin n_err++;
            $display("FAIL r14_first got idx=%0d type=%0d exp 14 0", round_key_idx2, round_type2); end
        lowc = 0;
        while (ready2 === 1'b0 && lowc < 40) begin
            lowc++;
            step();
        end
        n_cmp++; if (lowc !== 15) begin n_err++;
            $display("FAIL r14_latency got %0d busy cycles exp 15", lowc); end
        n_cmp++; if (result_valid2 !== 1'b1 || result2 !== (blk ^ {16{8'h0f}})) begin n_err++;
            $display("FAIL r14_result got vld=%b res=%h exp 1 %h", result_valid2, result2,
                     blk ^ {16{8'h0f}}); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        next = 1'b0;
        next2 = 1'b0;
        keymem_ready = 1'b1;
        block = '0;
        block2 = '0;
        test_reset();
        test_trace();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        test_rounds14();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
